// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM answering the core's multicycle memory port
// with a fixed access latency and a sticky illegal-request flag.
`default_nettype none
`timescale 1ns/1ps

package mem_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_access_size_t;
endpackage

module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [31:0]      rd_addr_i,
    input  mem_access_size_t rd_size_i,
    input  logic             rd_enable_i,
    input  logic [31:0]      wr_addr_i,
    input  mem_access_size_t wr_size_i,
    input  logic             wr_enable_i,
    input  logic [31:0]      wr_data_i,
    output logic [31:0]      rd_data_o,
    output logic             busy_o,
    output logic             error_o
);

    localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [3:0]       count, count_next;
    logic [AW+1:0]    addr_q;
    mem_access_size_t size_q;
    logic [31:0]      wdata_q;
    logic             write_q;
    logic [31:0]      rd_data;

    logic [31:0] mem [DEPTH];

    // Live request decode; write direction wins the mux, simultaneous enables are illegal anyway
    logic             req_valid, req_illegal, misaligned;
    logic [31:0]      req_addr;
    mem_access_size_t req_size;

    assign req_valid = rd_enable_i | wr_enable_i;
    assign req_addr  = wr_enable_i ? wr_addr_i : rd_addr_i;
    assign req_size  = wr_enable_i ? wr_size_i : rd_size_i;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = req_addr[0];
            WORD:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        req_illegal = (rd_enable_i & wr_enable_i) | misaligned
                    | (req_addr[31:2] >= 30'(DEPTH));
    end

    logic accept, complete;

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_illegal) begin
                        state_next = ERROR;
                    end else if (LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        state_next = BUSY;
                        count_next = LAT;
                    end
                end
            end
            BUSY: begin
                if (count <= 4'd1) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    // A zero-latency access completes from the live request; otherwise from the captured one
    logic [AW+1:0]    acc_addr;
    mem_access_size_t acc_size;
    logic [31:0]      acc_wdata;
    logic             acc_write;

    assign acc_addr  = (state == BUSY) ? addr_q  : req_addr[AW+1:0];
    assign acc_size  = (state == BUSY) ? size_q  : req_size;
    assign acc_wdata = (state == BUSY) ? wdata_q : wr_data_i;
    assign acc_write = (state == BUSY) ? write_q : wr_enable_i;

    logic [31:0] word, read_val, lanes;
    logic [3:0]  be;

    assign word = mem[acc_addr[AW+1:2]];

    always_comb begin
        read_val = word;
        lanes    = acc_wdata;
        be       = 4'b1111;
        case (acc_size)
            BYTE: begin
                read_val = {24'h0, word[{acc_addr[1:0], 3'b000} +: 8]};
                lanes    = {4{acc_wdata[7:0]}};
                be       = 4'b0001 << acc_addr[1:0];
            end
            HALF: begin
                read_val = {16'h0, acc_addr[1] ? word[31:16] : word[15:0]};
                lanes    = {2{acc_wdata[15:0]}};
                be       = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                read_val = word;
                lanes    = acc_wdata;
                be       = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (complete && acc_write && reset_ni) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[acc_addr[AW+1:2]][8*i +: 8] <= lanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            count   <= 4'd0;
            addr_q  <= '0;
            size_q  <= BYTE;
            wdata_q <= 32'h0;
            write_q <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept && !req_illegal) begin
                addr_q  <= req_addr[AW+1:0];
                size_q  <= req_size;
                wdata_q <= wr_data_i;
                write_q <= wr_enable_i;
            end
            if (complete && !acc_write) rd_data <= read_val;
        end
    end

    assign rd_data_o = rd_data;
    assign busy_o    = (state == BUSY);
    assign error_o   = (state == ERROR);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, hand sequences and a randomized run against a byte-level memory model.
`default_nettype none
`timescale 1ns/1ps

module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic [31:0]      rd_addr = '0, wr_addr = '0, wr_data = '0;
    mem_access_size_t rd_size = WORD, wr_size = WORD;
    logic             rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0]      rd_data;
    logic             busy, err;

    logic [31:0]      rd_addr0 = '0, wr_addr0 = '0, wr_data0 = '0;
    mem_access_size_t rd_size0 = WORD, wr_size0 = WORD;
    logic             rd_en0 = 1'b0, wr_en0 = 1'b0;
    logic [31:0]      rd_data0;
    logic             busy0, err0;

    mem_responder #(.DEPTH(1024), .LATENCY(2), .INIT_FILE("")) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .rd_addr_i(rd_addr), .rd_size_i(rd_size), .rd_enable_i(rd_en),
        .wr_addr_i(wr_addr), .wr_size_i(wr_size), .wr_enable_i(wr_en),
        .wr_data_i(wr_data), .rd_data_o(rd_data), .busy_o(busy), .error_o(err)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(0), .INIT_FILE("")) dut0 (
        .clk_i(clk), .reset_ni(rst_n),
        .rd_addr_i(rd_addr0), .rd_size_i(rd_size0), .rd_enable_i(rd_en0),
        .wr_addr_i(wr_addr0), .wr_size_i(wr_size0), .wr_enable_i(wr_en0),
        .wr_data_i(wr_data0), .rd_data_o(rd_data0), .busy_o(busy0), .error_o(err0)
    );

    int checks = 0;
    int errors = 0;
    bit busy0_seen = 1'b0;

    always @(negedge clk) if (busy0 === 1'b1) busy0_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory: one entry per byte address
    bit [7:0] model [int];

    function automatic int nbytes(input mem_access_size_t s);
        return (s == BYTE) ? 1 : (s == HALF) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input int a, input mem_access_size_t s);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nbytes(s); i++) v = v | (32'(model[a + i]) << (8 * i));
        return v;
    endfunction

    function automatic void model_write(input int a, input mem_access_size_t s, input logic [31:0] d);
        for (int i = 0; i < nbytes(s); i++) model[a + i] = d[8*i +: 8];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; rd_en0 = 1'b0; wr_en0 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One-cycle request pulse; returns busy-cycle count and outputs in the first non-busy cycle
    task automatic req(input bit w, input logic [31:0] a, input mem_access_size_t s,
                       input logic [31:0] d, input bit both,
                       output int nb, output logic [31:0] rd, output logic er);
        @(negedge clk);
        rd_addr = a; wr_addr = a; rd_size = s; wr_size = s; wr_data = d;
        rd_en = !w || both;
        wr_en = w || both;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 20) begin
            nb++;
            @(negedge clk);
        end
        rd = rd_data;
        er = err;
    endtask

    task automatic req0(input bit w, input logic [31:0] a, input mem_access_size_t s,
                        input logic [31:0] d, output logic bz, output logic [31:0] rd);
        @(negedge clk);
        rd_addr0 = a; wr_addr0 = a; rd_size0 = s; wr_size0 = s; wr_data0 = d;
        rd_en0 = !w; wr_en0 = w;
        @(negedge clk);
        rd_en0 = 1'b0; wr_en0 = 1'b0;
        bz = busy0;
        rd = rd_data0;
    endtask

    typedef struct {
        bit               wr;
        logic [31:0]      addr;
        mem_access_size_t size;
        logic [31:0]      wdata;
        logic [31:0]      exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        int          nb;
        logic [31:0] rd, last_rd, exp;
        logic        er, bz;
        logic [31:0] ill_addr [4];
        mem_access_size_t ill_size [4];
        bit          ill_both [4];

        tbl[0]  = '{1'b1, 32'h10, WORD, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 32'h10, WORD, 32'h0,        32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h20, WORD, 32'h11223344, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 32'h21, BYTE, 32'h123456AA, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 32'h22, HALF, 32'h9876BEEF, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 32'h20, WORD, 32'h0,        32'hBEEFAA44};
        tbl[6]  = '{1'b0, 32'h23, BYTE, 32'h0,        32'h000000BE};
        tbl[7]  = '{1'b0, 32'h20, HALF, 32'h0,        32'h0000AA44};
        tbl[8]  = '{1'b0, 32'h22, HALF, 32'h0,        32'h0000BEEF};
        tbl[9]  = '{1'b1, 32'h30, WORD, 32'h12345678, 32'h0000BEEF};
        tbl[10] = '{1'b0, 32'h31, BYTE, 32'h0,        32'h00000056};
        tbl[11] = '{1'b0, 32'h30, WORD, 32'h0,        32'h12345678};

        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset rd_data", rd_data, 32'h0);
        check("reset error", 32'(err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            req(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, 1'b0, nb, rd, er);
            check($sformatf("vec%0d busy cycles", i), 32'(nb), 32'd2);
            check($sformatf("vec%0d rd_data", i), rd, tbl[i].exp);
        end

        // Second request while busy must be ignored
        @(negedge clk);
        rd_addr = 32'h10; rd_size = WORD; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("overlap busy E1", 32'(busy), 32'h1);
        rd_addr = 32'h20; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("overlap busy E2", 32'(busy), 32'h1);
        @(negedge clk);
        check("overlap busy E3", 32'(busy), 32'h0);
        check("overlap rd_data E3", rd_data, 32'hDEADBEEF);
        @(negedge clk);
        check("overlap busy E4", 32'(busy), 32'h0);
        check("overlap rd_data E4", rd_data, 32'hDEADBEEF);

        // Reset during a pending write drops it
        @(negedge clk);
        wr_addr = 32'h30; wr_size = WORD; wr_data = 32'h55; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("midreset busy before", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy async", 32'(busy), 32'h0);
        check("midreset rd_data async", rd_data, 32'h0);
        check("midreset error async", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req(1'b0, 32'h30, WORD, 32'h0, 1'b0, nb, rd, er);
        check("midreset LW busy", 32'(nb), 32'd2);
        check("midreset LW old value", rd, 32'h12345678);

        ill_addr[0] = 32'h2;    ill_size[0] = WORD; ill_both[0] = 1'b0;
        ill_addr[1] = 32'h1;    ill_size[1] = HALF; ill_both[1] = 1'b0;
        ill_addr[2] = 32'h10;   ill_size[2] = WORD; ill_both[2] = 1'b1;
        ill_addr[3] = 32'h1000; ill_size[3] = WORD; ill_both[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            req(1'b0, ill_addr[i], ill_size[i], 32'h0, ill_both[i], nb, rd, er);
            check($sformatf("illegal%0d busy", i), 32'(nb), 32'd0);
            check($sformatf("illegal%0d error", i), 32'(er), 32'h1);
            req(1'b0, 32'h10, WORD, 32'h0, 1'b0, nb, rd, er);
            check($sformatf("illegal%0d later busy", i), 32'(nb), 32'd0);
            check($sformatf("illegal%0d error sticky", i), 32'(er), 32'h1);
            check($sformatf("illegal%0d rd_data held", i), rd, 32'h0);
        end

        // Zero-latency instance
        do_reset();
        req0(1'b1, 32'h0, WORD, 32'h00000013, bz, rd);
        check("lat0 SW busy", 32'(bz), 32'h0);
        check("lat0 SW rd_data", rd, 32'h0);
        req0(1'b0, 32'h0, WORD, 32'h0, bz, rd);
        check("lat0 LW busy", 32'(bz), 32'h0);
        check("lat0 LW rd_data", rd, 32'h00000013);
        req0(1'b0, 32'h1, BYTE, 32'h0, bz, rd);
        check("lat0 LB rd_data", rd, 32'h0);
        req0(1'b0, 32'h0, HALF, 32'h0, bz, rd);
        check("lat0 LH rd_data", rd, 32'h00000013);
        check("lat0 busy never high", 32'(busy0_seen), 32'h0);
        check("lat0 error", 32'(err0), 32'h0);

        // Randomized traffic over a preinitialised region
        last_rd = 32'h0;
        for (int i = 0; i < 32; i++) begin
            exp = $urandom;
            model_write(32'h100 + 4 * i, WORD, exp);
            req(1'b1, 32'h100 + 4 * i, WORD, exp, 1'b0, nb, rd, er);
            check("rand init busy", 32'(nb), 32'd2);
        end
        for (int i = 0; i < 60; i++) begin
            bit               w;
            mem_access_size_t s;
            int               a;
            logic [31:0]      d;
            w = 1'($urandom_range(0, 1));
            s = mem_access_size_t'($urandom_range(0, 2));
            a = 32'h100 + $urandom_range(0, 127);
            if (s == HALF) a = a & ~1;
            if (s == WORD) a = a & ~3;
            d = $urandom;
            req(w, 32'(a), s, d, 1'b0, nb, rd, er);
            if (w) model_write(a, s, d);
            else   last_rd = model_read(a, s);
            check($sformatf("rand%0d busy", i), 32'(nb), 32'd2);
            check($sformatf("rand%0d rd_data", i), rd, last_rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
